// File: rtl/gate_check_pkg.sv
// Shared constants for the on-board gate truth-table checker: FSM state
// encodings, reference truth tables and the default settle time.
package gate_check_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Reference 2-input truth tables; bit i is the output for stim == i
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

  // Default cycles between driving a vector and sampling the DUT
  localparam int unsigned DEFAULT_SETTLE_CYCLES = 50;

  // True for the states that make up an active run
  function automatic logic state_is_busy(input logic [2:0] s);
    return (s == ST_DRIVE) || (s == ST_SETTLE) ||
           (s == ST_SAMPLE) || (s == ST_NEXT);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that stops at zero; o_zero_c flags an expired count.
module settle_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  // Load on request, otherwise count down and hold at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Exhaustive truth-table checker for a small combinational gate in fabric.
// Steps stim through every input vector, waits SETTLE_CYCLES, samples
// dut_out and records mismatches against EXPECTED_TT.
// Optional build macro GATE_CHECK_STOP_ON_FAIL_EN: end the run at the first
// mismatching vector instead of exercising all vectors.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned          N_IN          = 2,
  parameter int unsigned          SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter logic [2**N_IN-1:0]   EXPECTED_TT   = TT_AND2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   fail_vec,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int unsigned NV = 2**N_IN;
  localparam int unsigned IW = N_IN + 1;
  localparam int unsigned CW = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [IW-1:0] LAST_IDX    = IW'(NV - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic            r_start_q;
  logic            w_start_acc;
  logic [IW-1:0]   r_idx;
  logic            w_timer_load;
  logic            w_timer_zero;
  logic            w_exp_bit;
  logic            w_mismatch;
  logic            w_enter_done;
  logic [NV-1:0]   w_fail_vec_nxt;

  // Settle-time counter, loaded while leaving DRIVE
  settle_timer #(
    .W (CW)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_timer_load),
    .i_load_val (SETTLE_LOAD),
    .o_zero_c   (w_timer_zero)
  );

  // Start edge is only meaningful when no run is active
  assign w_start_acc = start & ~r_start_q &
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Expected value for the current vector and the SAMPLE-cycle comparison
  assign w_exp_bit  = EXPECTED_TT[r_idx[N_IN-1:0]];
  assign w_mismatch = (r_state == ST_SAMPLE) && (dut_out != w_exp_bit);

  assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

  // Fail vector including a mismatch seen in the current SAMPLE cycle
  always_comb begin
    w_fail_vec_nxt = fail_vec;
    if (w_mismatch) begin
      w_fail_vec_nxt[r_idx[N_IN-1:0]] = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and timer load strobe
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_load = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_acc) begin
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        w_timer_load = 1'b1;
        w_state_nxt  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_timer_zero) begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        w_state_nxt = w_mismatch ? ST_DONE : ST_NEXT;
`else
        w_state_nxt = ST_NEXT;
`endif
      end
      ST_NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRIVE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Start edge register, vector index, stimulus and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_idx     <= '0;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_vec  <= '0;
      fail_idx  <= '0;
    end else begin
      r_start_q <= start;
      busy      <= state_is_busy(w_state_nxt);

      if (w_start_acc) begin
        r_idx    <= '0;
        stim     <= '0;
        done     <= 1'b0;
        pass     <= 1'b0;
        fail_vec <= '0;
        fail_idx <= '0;
      end else begin
        fail_vec <= w_fail_vec_nxt;

        if (r_state == ST_DRIVE) begin
          stim <= r_idx[N_IN-1:0];
        end

        // First mismatch of the run pins fail_idx
        if (w_mismatch && (fail_vec == '0)) begin
          fail_idx <= r_idx[N_IN-1:0];
        end

        if ((r_state == ST_NEXT) && (r_idx != LAST_IDX)) begin
          r_idx <= r_idx + IW'(1);
        end

        if (w_enter_done) begin
          pass <= (w_fail_vec_nxt == '0);
          done <= 1'b1;
          stim <= '0;
        end
      end
    end
  end

endmodule
